mem_page_reader: RTL
====================

Name: mem_page_reader

Overview:
Read-side sequencer that sits directly downstream of the paged dual-port memory block. On a start request it reads every valid entry of one memory page through the memory's read port, using the per-page entry counts the memory reports. It absorbs the memory's 2-cycle HIGH_PERFORMANCE read latency and streams the entries out over a valid/ready interface, with a small credit-controlled FIFO for backpressure.

Parameters:
RAM_WIDTH, 18, data width; must equal the memory's RAM_WIDTH.
RAM_DEPTH, 1024, memory depth; addrb width = clogb2(RAM_DEPTH).
PAGE_SIZE, 32, address stride between pages; page p base address = p*PAGE_SIZE.
NENT_WIDTH, 5, width of the entry-count inputs.
FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 4.

Ports:
clkb  in  1  single clock, shared with the memory read port.
rstb  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to read a page; sampled only in IDLE.
start_page  in  1  page to read (0 or 1), sampled with start.
nent_i0  in  NENT_WIDTH  entry count of page 0, from the memory's nent_o0.
nent_i1  in  NENT_WIDTH  entry count of page 1, from the memory's nent_o1.
addrb  out  clogb2(RAM_DEPTH)  memory read address.
enb  out  1  memory read enable.
regceb  out  1  memory output-register enable.
doutb  in  RAM_WIDTH  memory read data.
dout  out  RAM_WIDTH  streamed entry.
dout_valid  out  1  dout holds a valid entry.
dout_ready  in  1  consumer accepts dout.
dout_last  out  1  marks the final entry of the page; qualified by dout_valid.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse when the page is fully delivered.

Behaviour:
- Reset, on any clkb edge with rstb=1, overrides everything:
  - state -> IDLE.
  - FIFO, in-flight tracking and read-latency pipeline cleared.
  - All outputs go to 0: addrb, enb, dout, dout_valid, dout_last, busy, done.
  - regceb = 0 during reset, 1 otherwise.
- States:
  - IDLE: wait for start.
  - READ: issue reads.
  - DRAIN: wait for in-flight reads and the FIFO to empty.
- IDLE transitions:
  - start=1 latches page = start_page and count = nent_i<page>.
  - count=0: go to DRAIN, no read is issued, done pulses in the next cycle with no output beat.
  - count>0: go to READ with index=0.
- start asserted while busy is ignored. There is no queuing.
- READ issue rule:
  - A read issues in a cycle when (fifo_count + inflight) < FIFO_DEPTH.
  - An issued read drives enb=1 and addrb = page*PAGE_SIZE + index, then index increments.
  - After the read with index = count-1 issues, go to DRAIN.
  - The FIFO pop in the same cycle is not counted toward the credit check (conservative).
- Latency: a read issued in cycle T presents its data on doutb in cycle T+2. That data is written into the FIFO at the end of T+2 and is visible on dout from cycle T+3.
- Throughput: with dout_ready held high, one beat per cycle with no bubbles for FIFO_DEPTH=4.
- First-beat timing: start in cycle 0 -> first enb in cycle 1 -> first dout_valid in cycle 4.
- Output handshake:
  - A beat transfers when dout_valid && dout_ready.
  - dout and dout_last hold steady while dout_valid && !dout_ready.
  - dout_last=1 only on the beat whose index = count-1.
- DRAIN: when inflight=0 and the FIFO is empty, pulse done for exactly one cycle and return to IDLE. A new start is accepted from the cycle after done.
- Width rules:
  - index and count are NENT_WIDTH bits.
  - Address arithmetic is done at clogb2(RAM_DEPTH) width.
  - count > PAGE_SIZE is clamped to PAGE_SIZE.
- nent_i0 and nent_i1 changing after start is accepted has no effect on the current page.
- Simultaneous FIFO write and pop in the same cycle: occupancy is unchanged. The FIFO never overflows by construction; the verifier checks this with an assertion.

Test Plan:
- Page 0 with nent_i0=3, memory words 0..2 = 18'h00011/00022/00033, dout_ready=1, start in cycle 0 -> enb in cycles 1-3 with addrb 0,1,2; dout_valid in cycles 4-6 carrying 11,22,33; dout_last only in cycle 6; done in cycle 7; busy in cycles 1-7.
- Page 1 with nent_i1=2 -> addrb 32,33; two beats; dout_last on the second beat.
- nent_i0=0, start page 0 -> enb never asserted; dout_valid never asserted; done pulses in cycle 2.
- Page 0 with nent_i0=10, dout_ready low for cycles 4-12 -> at most 4 reads outstanding or buffered; dout holds entry 0 steady; all 10 entries later delivered in order with none lost or duplicated.
- start re-asserted in cycle 2 of a running read -> ignored; exactly one done pulse and the original entry count delivered.
- rstb=1 in cycle 5 of a 10-entry read -> all outputs 0 in the next cycle; a fresh start afterwards reads the page from addrb 0.

Source files
------------

// File: rtl/mem_page_reader.sv
// Read-side sequencer for the paged dual-port memory: reads one page through port B,
// hides the 2-cycle registered read latency and streams entries over valid/ready.
module mem_page_reader #(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    parameter int PAGE_SIZE  = 32,
    parameter int NENT_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clkb,
    input  logic                         rstb,
    input  logic                         start,
    input  logic                         start_page,
    input  logic [NENT_WIDTH-1:0]        nent_i0,
    input  logic [NENT_WIDTH-1:0]        nent_i1,
    output logic [$clog2(RAM_DEPTH)-1:0] addrb,
    output logic                         enb,
    output logic                         regceb,
    input  logic [RAM_WIDTH-1:0]         doutb,
    output logic [RAM_WIDTH-1:0]         dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         dout_last,
    output logic                         busy,
    output logic                         done
);

    localparam int ADDR_W = $clog2(RAM_DEPTH);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state;
    logic                  page;
    logic [NENT_WIDTH-1:0] count;
    logic [NENT_WIDTH-1:0] index;
    logic                  done_r;

    logic [NENT_WIDTH-1:0] nent_sel;
    logic [ADDR_W-1:0]     page_base;
    logic [1:0]            inflight;
    logic                  credit_ok;
    logic                  issue;
    logic                  is_last;
    logic                  drain_ok;

    // Read-latency pipeline: bit 0 = issued last cycle, bit 1 = data on doutb now.
    logic [1:0]            pipe_v;
    logic [1:0]            pipe_last;

    logic [RAM_WIDTH:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        fifo_count;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [RAM_WIDTH:0]    head;

    // NOTE: the first assignment gives nent_sel a value on every path, so no latch is inferred.
    always_comb begin
        nent_sel = start_page ? nent_i1 : nent_i0;
        if (int'(nent_sel) > PAGE_SIZE) begin
            nent_sel = NENT_WIDTH'(PAGE_SIZE);
        end
    end

    assign page_base = page ? ADDR_W'(PAGE_SIZE) : '0;
    assign inflight  = {1'b0, pipe_v[0]} + {1'b0, pipe_v[1]};

    // Credit ignores a same-cycle pop, so a slot is only reused once it is really free.
    assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign issue     = (state == ST_READ) && credit_ok;
    assign is_last   = (index == (count - NENT_WIDTH'(1)));

    assign fifo_wr    = pipe_v[1];
    assign dout_valid = (fifo_count != '0);
    assign fifo_rd    = dout_valid && dout_ready;
    assign head       = fifo_mem[rd_ptr];

    // Page is complete once nothing is in flight and the FIFO empties by the end of this cycle.
    assign drain_ok = (inflight == 2'd0) &&
                      ((fifo_count == '0) ||
                       ((fifo_count == (PTR_W+1)'(1)) && fifo_rd));

    assign enb       = issue;
    assign addrb     = issue ? (page_base + ADDR_W'(index)) : '0;
    assign regceb    = ~rstb;
    assign dout      = dout_valid ? head[RAM_WIDTH-1:0] : '0;
    assign dout_last = dout_valid & head[RAM_WIDTH];
    assign busy      = (state != ST_IDLE);
    assign done      = done_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkb) begin
        if (rstb) begin
            state  <= ST_IDLE;
            page   <= 1'b0;
            count  <= '0;
            index  <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        page  <= start_page;
                        count <= nent_sel;
                        index <= '0;
                        state <= (nent_sel == '0) ? ST_DRAIN : ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        index <= index + NENT_WIDTH'(1);
                        if (is_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done_r) begin
                        state <= ST_IDLE;
                    end else if (drain_ok) begin
                        done_r <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            pipe_v    <= {pipe_v[0], issue};
            pipe_last <= {pipe_last[0], issue & is_last};
        end
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; fifo_count gates every read, so stale words are never seen.
    always_ff @(posedge clkb) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= {pipe_last[1], doutb};
        end
    end

endmodule
